best_1ofn_busy_pipe: RTL

Parametrised, pipelined successor to the combinational best-1-of-5 ccLUT pattern selector. It picks the highest-quality non-busy candidate among `NCH` pattern-finder channels and registers the result through a compare tree of fixed latency. It also enforces a programmable per-channel dead time after each win. It sits between the per-group ccLUT pattern finders and the CLCT builder in the TMB trigger path.

---
 rtl/best_1ofn_busy_pipe_if.sv | 35 +++
 rtl/best_1ofn_busy_pipe.sv | 108 ++++++++++
 2 files changed

// File: rtl/best_1ofn_busy_pipe_if.sv
// Candidate bus and winner bus for best_1ofn_busy_pipe.
// master: pattern-finder side; slave: selector side.
interface best_1ofn_busy_pipe_if #(
   parameter int NCH    = 5,
   parameter int PATB   = 7,
   parameter int KEYB   = 5,
   parameter int CARRYB = 12
);
   localparam int IDXB = $clog2(NCH);

   logic                   in_vld;
   logic [NCH*PATB-1:0]    pat;
   logic [NCH*KEYB-1:0]    key;
   logic [NCH*CARRYB-1:0]  carry;
   logic [NCH-1:0]         bsy;

   logic                   best_vld;
   logic [PATB-1:0]        best_pat;
   logic [IDXB+KEYB-1:0]   best_key;
   logic [CARRYB-1:0]      best_carry;
   logic [IDXB-1:0]        best_idx;
   logic                   best_bsy;

   modport master (
      output in_vld, pat, key, carry, bsy,
      input  best_vld, best_pat, best_key,
      input  best_carry, best_idx, best_bsy
   );

   modport slave (
      input  in_vld, pat, key, carry, bsy,
      output best_vld, best_pat, best_key,
      output best_carry, best_idx, best_bsy
   );
endinterface

// File: rtl/best_1ofn_busy_pipe.sv
// Pipelined best-1-of-N pattern selector with per-channel dead time.
// Ports: clock, reset_n (async low), bus (slave: candidates in, winner out).
module best_1ofn_busy_pipe #(
   parameter int NCH       = 5,
   parameter int PATB      = 7,
   parameter int KEYB      = 5,
   parameter int CARRYB    = 12,
   parameter int DEAD_CLKS = 0
) (
   input logic clock,
   input logic reset_n,
   best_1ofn_busy_pipe_if.slave bus
);
   localparam int IDXB = $clog2(NCH);
   localparam int LV   = IDXB;

   function automatic int cnt_at(input int l);
      int n;
      n = NCH;
      for (int k = 0; k < l; k++) n = (n + 1) / 2;
      return n;
   endfunction

   function automatic int off_at(input int l);
      int o;
      o = 0;
      for (int k = 0; k < l; k++) o += cnt_at(k);
      return o;
   endfunction

   localparam int TOT  = off_at(LV + 1);
   localparam int ROOT = off_at(LV);
   localparam logic [7:0] DC = 8'(DEAD_CLKS);

   // Ineligible nodes always carry all-zero data, so the root
   // drives zeros on the outputs without an extra mux.
   typedef struct packed {
      logic              el;
      logic [PATB-1:0]   pat;
      logic [KEYB-1:0]   key;
      logic [CARRYB-1:0] carry;
      logic [IDXB-1:0]   idx;
   } node_t;

   // Left child always holds the lower channel indices,
   // so ">=" resolves ties toward the lower index.
   function automatic node_t pick(input node_t a, input node_t b);
      if (a.el && (!b.el ||
          a.pat[PATB-1:1] >= b.pat[PATB-1:1]))
         return a;
      return b;
   endfunction

   node_t      d [TOT];
   node_t      q [TOT];
   logic [7:0] dcnt [NCH];

   for (genvar i = 0; i < NCH; i++) begin : g_in
      logic el;
      assign el = bus.in_vld & ~bus.bsy[i] &
                  (dcnt[i] == 8'd0);
      assign d[i] = el ? {1'b1,
                          bus.pat[i*PATB +: PATB],
                          bus.key[i*KEYB +: KEYB],
                          bus.carry[i*CARRYB +: CARRYB],
                          IDXB'(i)}
                       : '0;
   end

   for (genvar l = 1; l <= LV; l++) begin : g_lv
      for (genvar j = 0; j < cnt_at(l); j++) begin : g_nd
         localparam int A = off_at(l - 1) + 2 * j;
         localparam int Y = off_at(l) + j;
         if (2 * j + 1 < cnt_at(l - 1)) begin : g_cmp
            assign d[Y] = pick(q[A], q[A + 1]);
         end else begin : g_pass
            assign d[Y] = q[A];
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) q <= '{default: '0};
      else          q <= d;
   end

   // Reload on the edge the root captures a win; this also
   // covers wins by candidates that were already in flight.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         dcnt <= '{default: '0};
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (d[ROOT].el && d[ROOT].idx == IDXB'(i))
               dcnt[i] <= DC;
            else if (dcnt[i] != 8'd0)
               dcnt[i] <= dcnt[i] - 8'd1;
         end
      end
   end

   assign bus.best_vld   = q[ROOT].el;
   assign bus.best_bsy   = ~q[ROOT].el;
   assign bus.best_pat   = q[ROOT].pat;
   assign bus.best_key   = {q[ROOT].idx, q[ROOT].key};
   assign bus.best_carry = q[ROOT].carry;
   assign bus.best_idx   = q[ROOT].idx;
endmodule
